// File: rtl/lighting_actuator_driver_if.sv
// Target handshake between the lighting controller and the actuator driver.
// The controller drives a lamp pattern and shade level; the driver answers with ready.
interface lighting_actuator_driver_if;
    logic        tgt_valid;
    logic        tgt_ready;
    logic [15:0] tgt_light;
    logic [3:0]  tgt_shade;

    modport master (
        output tgt_valid,
        output tgt_light,
        output tgt_shade,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid,
        input  tgt_light,
        input  tgt_shade,
        output tgt_ready
    );
endinterface

// File: rtl/lighting_actuator_driver.sv
// Moves lamp outputs and shade position toward a latched target, one lamp toggle
// and one shade step per step tick, then pulses done once the target is reached.
//
// state  | meaning
// IDLE   | ready for a new target, outputs hold the last applied state
// APPLY  | stepping lamps/shade toward the latched target on every tick
// DONE   | target reached, done pulses for one cycle
module lighting_actuator_driver #(
    parameter int STEP_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    lighting_actuator_driver_if.slave   tgt,
    output logic [15:0]                 lamp_out,
    output logic [3:0]                  shade_pos,
    output logic                        motor_up,
    output logic                        motor_dn,
    output logic [4:0]                  lamp_cnt,
    output logic                        busy,
    output logic                        done
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] TICK_CNT = CNT_W'(STEP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      lamp_q, lamp_d;
    logic [3:0]       shade_q, shade_d;
    logic [15:0]      tgt_light_q, tgt_light_d;
    logic [3:0]       tgt_shade_q, tgt_shade_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             motor_up_q, motor_up_d;
    logic             motor_dn_q, motor_dn_d;

    logic [15:0]      lamp_diff;
    logic [15:0]      lamp_low_bit;

    // Isolate the lowest differing lamp so only one lamp switches per tick.
    assign lamp_diff    = lamp_q ^ tgt_light_q;
    assign lamp_low_bit = lamp_diff & (~lamp_diff + 16'd1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lamp_d      = lamp_q;
        shade_d     = shade_q;
        tgt_light_d = tgt_light_q;
        tgt_shade_d = tgt_shade_q;

        unique case (state_q)
            ST_IDLE: begin
                if (tgt.tgt_valid && ready_q) begin
                    tgt_light_d = tgt.tgt_light;
                    tgt_shade_d = tgt.tgt_shade;
                    cnt_d       = '0;
                    state_d     = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (lamp_q == tgt_light_q && shade_q == tgt_shade_q) begin
                    state_d = ST_DONE;
                end else if (cnt_q == TICK_CNT) begin
                    cnt_d  = '0;
                    lamp_d = lamp_q ^ lamp_low_bit;
                    if (shade_q < tgt_shade_q) begin
                        shade_d = shade_q + 4'd1;
                    end else if (shade_q > tgt_shade_q) begin
                        shade_d = shade_q - 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next-state view so they line up with the state.
        ready_d    = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        motor_up_d = (state_d == ST_APPLY) && (shade_d < tgt_shade_d);
        motor_dn_d = (state_d == ST_APPLY) && (shade_d > tgt_shade_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lamp_q      <= '0;
            shade_q     <= '0;
            tgt_light_q <= '0;
            tgt_shade_q <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            motor_up_q  <= 1'b0;
            motor_dn_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lamp_q      <= lamp_d;
            shade_q     <= shade_d;
            tgt_light_q <= tgt_light_d;
            tgt_shade_q <= tgt_shade_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            motor_up_q  <= motor_up_d;
            motor_dn_q  <= motor_dn_d;
        end
    end

    assign tgt.tgt_ready = ready_q;
    assign lamp_out      = lamp_q;
    assign shade_pos     = shade_q;
    assign lamp_cnt      = 5'($countones(lamp_q));
    assign busy          = busy_q;
    assign done          = done_q;
    assign motor_up      = motor_up_q;
    assign motor_dn      = motor_dn_q;
endmodule

// File: tb/tb_lighting_actuator_driver.sv
// Bench for lighting_actuator_driver: directed and random targets checked cycle by
// cycle against a step-schedule model of the actuator.
module tb_lighting_actuator_driver;
    localparam int S = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] lamp_out;
    logic [3:0]  shade_pos;
    logic        motor_up;
    logic        motor_dn;
    logic [4:0]  lamp_cnt;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Model of the physically applied state.
    logic [15:0] m_lamp;
    int          m_shade;

    lighting_actuator_driver_if tgt ();

    lighting_actuator_driver #(
        .STEP_CYCLES(S),
        .CNT_W      (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tgt      (tgt.slave),
        .lamp_out (lamp_out),
        .shade_pos(shade_pos),
        .motor_up (motor_up),
        .motor_dn (motor_dn),
        .lamp_cnt (lamp_cnt),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one target and compare every cycle until the block is back in IDLE.
    // With jam set, a conflicting target is held on the bus during the whole apply.
    task automatic run_target(input logic [15:0] l, input logic [3:0] s, input bit jam);
        int w;
        int n_lamp;
        int n_shade;
        int n_steps;
        int total;
        bit in_apply;
        logic [15:0] e_lamp;
        int e_shade;
        w = 0;
        while (tgt.tgt_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (tgt.tgt_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait: tgt_ready=%b after %0d cycles, required 1", tgt.tgt_ready, w);
            return;
        end
        tgt.tgt_valid = 1'b1;
        tgt.tgt_light = l;
        tgt.tgt_shade = s;
        @(posedge clk); #1;
        if (jam) begin
            tgt.tgt_light = 16'hFFFF;
            tgt.tgt_shade = 4'hF;
        end else begin
            tgt.tgt_valid = 1'b0;
        end

        n_lamp  = $countones(l ^ m_lamp);
        n_shade = (int'(s) > m_shade) ? int'(s) - m_shade : m_shade - int'(s);
        n_steps = (n_lamp > n_shade) ? n_lamp : n_shade;
        total   = n_steps * S + 2;

        for (int c = 1; c <= total; c++) begin
            @(posedge clk); #1;
            if (c % S == 0 && c / S <= n_steps) begin
                for (int i = 0; i < 16; i++) begin
                    if (m_lamp[i] != l[i]) begin
                        m_lamp[i] = l[i];
                        break;
                    end
                end
                if (m_shade < int'(s)) m_shade++;
                else if (m_shade > int'(s)) m_shade--;
            end
            e_lamp   = m_lamp;
            e_shade  = m_shade;
            in_apply = (c <= n_steps * S);

            checks++;
            if (lamp_out !== e_lamp) begin
                errors++;
                $display("FAIL lamp_out c=%0d: got %h, required %h", c, lamp_out, e_lamp);
            end
            checks++;
            if (shade_pos !== 4'(e_shade)) begin
                errors++;
                $display("FAIL shade_pos c=%0d: got %0d, required %0d", c, shade_pos, e_shade);
            end
            checks++;
            if (lamp_cnt !== 5'($countones(e_lamp))) begin
                errors++;
                $display("FAIL lamp_cnt c=%0d: got %0d, required %0d", c, lamp_cnt, $countones(e_lamp));
            end
            checks++;
            if (motor_up !== (in_apply && e_shade < int'(s))) begin
                errors++;
                $display("FAIL motor_up c=%0d: got %b, required %b", c, motor_up, in_apply && e_shade < int'(s));
            end
            checks++;
            if (motor_dn !== (in_apply && e_shade > int'(s))) begin
                errors++;
                $display("FAIL motor_dn c=%0d: got %b, required %b", c, motor_dn, in_apply && e_shade > int'(s));
            end
            checks++;
            if (busy !== (c <= n_steps * S + 1)) begin
                errors++;
                $display("FAIL busy c=%0d: got %b, required %b", c, busy, c <= n_steps * S + 1);
            end
            checks++;
            if (done !== (c == n_steps * S + 1)) begin
                errors++;
                $display("FAIL done c=%0d: got %b, required %b", c, done, c == n_steps * S + 1);
            end
            checks++;
            if (tgt.tgt_ready !== (c == total)) begin
                errors++;
                $display("FAIL tgt_ready c=%0d: got %b, required %b", c, tgt.tgt_ready, c == total);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tgt.tgt_valid = 1'b0;
        tgt.tgt_light = 16'h0;
        tgt.tgt_shade = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_lamp  = 16'h0;
        m_shade = 0;
        checks++;
        if (lamp_out !== 16'h0000) begin
            errors++; $display("FAIL reset_lamp: got %h, required 0000", lamp_out);
        end
        checks++;
        if (shade_pos !== 4'd0) begin
            errors++; $display("FAIL reset_shade: got %0d, required 0", shade_pos);
        end
        checks++;
        if (tgt.tgt_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b, required 1", tgt.tgt_ready);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_busy_done: got %b/%b, required 0/0", busy, done);
        end
        checks++;
        if (lamp_cnt !== 5'd0) begin
            errors++; $display("FAIL reset_lamp_cnt: got %0d, required 0", lamp_cnt);
        end
        checks++;
        if (motor_up !== 1'b0 || motor_dn !== 1'b0) begin
            errors++; $display("FAIL reset_motor: got %b/%b, required 0/0", motor_up, motor_dn);
        end
    endtask

    task automatic test_basic();
        run_target(16'h0005, 4'd2, 1'b0);
        checks++;
        if (lamp_out !== 16'h0005 || lamp_cnt !== 5'd2) begin
            errors++; $display("FAIL basic_final: got %h/%0d, required 0005/2", lamp_out, lamp_cnt);
        end
        run_target(16'h8000, 4'd0, 1'b0);
        checks++;
        if (lamp_out !== 16'h8000 || shade_pos !== 4'd0) begin
            errors++; $display("FAIL basic2_final: got %h/%0d, required 8000/0", lamp_out, shade_pos);
        end
    endtask

    task automatic test_identical();
        run_target(m_lamp, 4'(m_shade), 1'b0);
    endtask

    task automatic test_back_to_back();
        run_target(16'h0300, 4'd3, 1'b1);
        run_target(16'hFFFF, 4'hF, 1'b0);
        run_target(16'h0000, 4'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] l;
        logic [3:0]  s;
        for (int k = 0; k < 8; k++) begin
            l = 16'($urandom);
            s = 4'($urandom_range(15, 0));
            if (k == 3) l = m_lamp;
            run_target(l, s, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        w = 0;
        while (tgt.tgt_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        tgt.tgt_valid = 1'b1;
        tgt.tgt_light = 16'hFFFF;
        tgt.tgt_shade = 4'hF;
        @(posedge clk); #1;
        tgt.tgt_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL midrst_busy_before: got %b, required 1", busy);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_lamp  = 16'h0;
        m_shade = 0;
        checks++;
        if (lamp_out !== 16'h0 || shade_pos !== 4'd0) begin
            errors++; $display("FAIL midrst_state: got %h/%0d, required 0000/0", lamp_out, shade_pos);
        end
        checks++;
        if (tgt.tgt_ready !== 1'b1 || busy !== 1'b0 || motor_up !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ctrl: ready/busy/motor_up got %b/%b/%b, required 1/0/0", tgt.tgt_ready, busy, motor_up);
        end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || lamp_out !== 16'h0) begin
                errors++; $display("FAIL midrst_idle c=%0d: done/lamp got %b/%h, required 0/0000", c, done, lamp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_identical();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_basic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
